id_stage_pipelined: RTL and testbench

// - Parametrised MIPS instruction-decode stage with a registered ID/EX boundary.
// - Holds a 2-read/1-write register file with write-back bypass and decodes opcode/funct into control.
// - Sign- or zero-extends the immediate and detects load-use hazards (stall + bubble).
// - Sits between the IF/ID register and the execute stage; output is 1 cycle after instruction.

---
 rtl/id_stage_pipelined_pkg.sv | 50 +++++
 rtl/id_stage_pipelined_reg_file.sv | 47 ++++
 rtl/id_stage_pipelined.sv | 122 ++++++++++++
 tb/tb_id_stage_pipelined.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pipelined_pkg.sv
// Shared MIPS decode constants and the control bundle produced by the ID stage.
// The opcode/funct table lives here so every stage decodes the same way.
package id_stage_pipelined_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [5:0] ALU_ADD = 6'h20;
    localparam logic [5:0] ALU_SUB = 6'h22;
    localparam logic [5:0] ALU_AND = 6'h24;
    localparam logic [5:0] ALU_OR  = 6'h25;

    typedef struct packed {
        logic [5:0] alu_op;
        logic       alu_src;
        logic       reg_dst;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       branch;
        logic       zero_ext;
    } ctrl_t;

    // Unknown opcodes fall through to an all-zero bundle, i.e. a NOP.
    function automatic ctrl_t decode_ctrl(input logic [5:0] opcode, input logic [5:0] funct);
        ctrl_t c;
        c = '0;
        case (opcode)
            OP_RTYPE: begin c.alu_op = funct;   c.reg_dst = 1'b1; c.reg_write = 1'b1; end
            OP_LW:    begin c.alu_op = ALU_ADD; c.alu_src = 1'b1; c.mem_read = 1'b1;
                            c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
            OP_SW:    begin c.alu_op = ALU_ADD; c.alu_src = 1'b1; c.mem_write = 1'b1; end
            OP_ADDI:  begin c.alu_op = ALU_ADD; c.alu_src = 1'b1; c.reg_write = 1'b1; end
            OP_ANDI:  begin c.alu_op = ALU_AND; c.alu_src = 1'b1; c.reg_write = 1'b1;
                            c.zero_ext = 1'b1; end
            OP_ORI:   begin c.alu_op = ALU_OR;  c.alu_src = 1'b1; c.reg_write = 1'b1;
                            c.zero_ext = 1'b1; end
            OP_BEQ:   begin c.alu_op = ALU_SUB; c.branch = 1'b1; end
            default:  c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/id_stage_pipelined_reg_file.sv
// Two-read / one-write register file with hard-wired zero register and
// optional same-cycle write-back forwarding onto the read ports.
module reg_file_2r1w
    import id_stage_pipelined_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int BYPASS_WB  = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [REG_ADDR_W-1:0] raddr1,
    input  logic [REG_ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0]     rdata1,
    output logic [DATA_W-1:0]     rdata2
);

    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    logic [DATA_W-1:0] mem [NUM_REGS];
    logic              wr_valid;

    assign wr_valid = we && (waddr != '0);

    // NOTE: the array is cleared by reset because a reset must leave every register reading zero; this rules out a RAM macro.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
        end else if (wr_valid) begin
            mem[waddr] <= wdata;
        end
    end

    // NOTE: each output gets a default before any condition so no latch is inferred.
    always_comb begin
        rdata1 = mem[raddr1];
        rdata2 = mem[raddr2];
        if (BYPASS_WB != 0 && wr_valid && waddr == raddr1) rdata1 = wdata;
        if (BYPASS_WB != 0 && wr_valid && waddr == raddr2) rdata2 = wdata;
        if (raddr1 == '0) rdata1 = '0;
        if (raddr2 == '0) rdata2 = '0;
    end

endmodule

// File: rtl/id_stage_pipelined.sv
// MIPS instruction-decode stage: register read, control decode, immediate
// extension, load-use hazard detection and the registered ID/EX boundary.
module id_stage_pipelined
    import id_stage_pipelined_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int IMM_W      = 16,
    parameter int BYPASS_WB  = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  flush,
    input  logic [31:0]           instruction,
    input  logic [DATA_W-1:0]     pc_plus4,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    output logic                  stall,
    output logic [DATA_W-1:0]     id_reg_data1,
    output logic [DATA_W-1:0]     id_reg_data2,
    output logic [DATA_W-1:0]     id_imm,
    output logic [DATA_W-1:0]     id_pc_plus4,
    output logic [REG_ADDR_W-1:0] id_rs,
    output logic [REG_ADDR_W-1:0] id_rt,
    output logic [REG_ADDR_W-1:0] id_rd,
    output logic [5:0]            id_alu_op,
    output logic                  id_alu_src,
    output logic                  id_reg_dst,
    output logic                  id_mem_read,
    output logic                  id_mem_write,
    output logic                  id_reg_write,
    output logic                  id_mem_to_reg,
    output logic                  id_branch
);

    logic [REG_ADDR_W-1:0] rs, rt, rd;
    logic [IMM_W-1:0]      imm_field;
    logic [DATA_W-1:0]     imm_ext;
    logic [DATA_W-1:0]     rdata1, rdata2;
    ctrl_t                 ctrl;
    logic                  bubble;

    assign rs        = REG_ADDR_W'(instruction[25:21]);
    assign rt        = REG_ADDR_W'(instruction[20:16]);
    assign rd        = REG_ADDR_W'(instruction[15:11]);
    assign imm_field = instruction[IMM_W-1:0];
    assign ctrl      = decode_ctrl(instruction[31:26], instruction[5:0]);
    assign imm_ext   = ctrl.zero_ext ? DATA_W'(imm_field) : DATA_W'($signed(imm_field));

    // A taken branch squashes this instruction anyway, so it never needs to wait on a load.
    assign stall  = ex_mem_read && (ex_rt != '0) && (ex_rt == rs || ex_rt == rt) && !flush;
    assign bubble = flush || stall;

    reg_file_2r1w #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W),
        .BYPASS_WB  (BYPASS_WB)
    ) u_reg_file (
        .clock  (clock),
        .reset  (reset),
        .we     (wb_we),
        .waddr  (wb_addr),
        .wdata  (wb_data),
        .raddr1 (rs),
        .raddr2 (rt),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    // Data fields load even on a bubble; only the controls are forced to zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            id_reg_data1  <= '0;
            id_reg_data2  <= '0;
            id_imm        <= '0;
            id_pc_plus4   <= '0;
            id_rs         <= '0;
            id_rt         <= '0;
            id_rd         <= '0;
            id_alu_op     <= '0;
            id_alu_src    <= 1'b0;
            id_reg_dst    <= 1'b0;
            id_mem_read   <= 1'b0;
            id_mem_write  <= 1'b0;
            id_reg_write  <= 1'b0;
            id_mem_to_reg <= 1'b0;
            id_branch     <= 1'b0;
        end else if (enable) begin
            id_reg_data1 <= rdata1;
            id_reg_data2 <= rdata2;
            id_imm       <= imm_ext;
            id_pc_plus4  <= pc_plus4;
            id_rs        <= rs;
            id_rt        <= rt;
            id_rd        <= rd;
            if (bubble) begin
                id_alu_op     <= '0;
                id_alu_src    <= 1'b0;
                id_reg_dst    <= 1'b0;
                id_mem_read   <= 1'b0;
                id_mem_write  <= 1'b0;
                id_reg_write  <= 1'b0;
                id_mem_to_reg <= 1'b0;
                id_branch     <= 1'b0;
            end else begin
                id_alu_op     <= ctrl.alu_op;
                id_alu_src    <= ctrl.alu_src;
                id_reg_dst    <= ctrl.reg_dst;
                id_mem_read   <= ctrl.mem_read;
                id_mem_write  <= ctrl.mem_write;
                id_reg_write  <= ctrl.reg_write;
                id_mem_to_reg <= ctrl.mem_to_reg;
                id_branch     <= ctrl.branch;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Self-checking bench for id_stage_pipelined: directed cases plus randomized
// traffic against a table-driven reference model; both bypass settings are run.
module tb_id_stage_pipelined;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable, flush, wb_we, ex_mem_read;
    logic [31:0] instruction, pc_plus4, wb_data;
    logic [4:0]  wb_addr, ex_rt;

    logic        stall, stall_nb;
    logic [31:0] d1, d2, imm, pc, d1_nb, d2_nb, imm_nb, pc_nb;
    logic [4:0]  rs_o, rt_o, rd_o, rs_nb, rt_nb, rd_nb;
    logic [5:0]  alu_op, alu_op_nb;
    logic        alu_src, reg_dst, mem_read, mem_write, reg_write, mem_to_reg, branch;
    logic        alu_src_nb, reg_dst_nb, mem_read_nb, mem_write_nb, reg_write_nb, mem_to_reg_nb, branch_nb;

    always #5 clock = ~clock;

    id_stage_pipelined #(.BYPASS_WB(1)) dut (
        .clock(clock), .reset(reset), .enable(enable), .flush(flush),
        .instruction(instruction), .pc_plus4(pc_plus4),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .stall(stall),
        .id_reg_data1(d1), .id_reg_data2(d2), .id_imm(imm), .id_pc_plus4(pc),
        .id_rs(rs_o), .id_rt(rt_o), .id_rd(rd_o), .id_alu_op(alu_op),
        .id_alu_src(alu_src), .id_reg_dst(reg_dst), .id_mem_read(mem_read),
        .id_mem_write(mem_write), .id_reg_write(reg_write),
        .id_mem_to_reg(mem_to_reg), .id_branch(branch)
    );

    id_stage_pipelined #(.BYPASS_WB(0)) dut_nb (
        .clock(clock), .reset(reset), .enable(enable), .flush(flush),
        .instruction(instruction), .pc_plus4(pc_plus4),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .stall(stall_nb),
        .id_reg_data1(d1_nb), .id_reg_data2(d2_nb), .id_imm(imm_nb), .id_pc_plus4(pc_nb),
        .id_rs(rs_nb), .id_rt(rt_nb), .id_rd(rd_nb), .id_alu_op(alu_op_nb),
        .id_alu_src(alu_src_nb), .id_reg_dst(reg_dst_nb), .id_mem_read(mem_read_nb),
        .id_mem_write(mem_write_nb), .id_reg_write(reg_write_nb),
        .id_mem_to_reg(mem_to_reg_nb), .id_branch(branch_nb)
    );

    wire [12:0] got_ctrl    = {alu_op, alu_src, reg_dst, mem_read, mem_write, reg_write, mem_to_reg, branch};
    wire [12:0] got_ctrl_nb = {alu_op_nb, alu_src_nb, reg_dst_nb, mem_read_nb, mem_write_nb,
                               reg_write_nb, mem_to_reg_nb, branch_nb};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state: architectural registers and the expected ID/EX contents.
    logic [31:0] m_rf [32];
    logic [12:0] exp_ctrl;
    logic [31:0] exp_d1, exp_d2, exp_d1_nb, exp_d2_nb, exp_imm, exp_pc;
    logic [4:0]  exp_rs, exp_rt, exp_rd;
    bit          exp_valid;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        exp_ctrl = '0; exp_d1 = '0; exp_d2 = '0; exp_d1_nb = '0; exp_d2_nb = '0;
        exp_imm = '0; exp_pc = '0; exp_rs = '0; exp_rt = '0; exp_rd = '0;
        exp_valid = 1'b1;
    endtask

    // {zero_ext, alu_op, alu_src, reg_dst, mem_read, mem_write, reg_write, mem_to_reg, branch}
    function automatic logic [13:0] ref_decode(input logic [31:0] ins);
        case (ins[31:26])
            6'h00:   return {1'b0, ins[5:0], 7'b0100100};
            6'h23:   return {1'b0, 6'h20, 7'b1010110};
            6'h2B:   return {1'b0, 6'h20, 7'b1001000};
            6'h08:   return {1'b0, 6'h20, 7'b1000100};
            6'h0C:   return {1'b1, 6'h24, 7'b1000100};
            6'h0D:   return {1'b1, 6'h25, 7'b1000100};
            6'h04:   return {1'b0, 6'h22, 7'b0000001};
            default: return 14'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a, input bit byp, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
        if (a == 0) return 32'h0;
        if (byp && we && wa == a) return wd;
        return m_rf[a];
    endfunction

    function automatic logic [31:0] r_ins(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    task automatic check_outputs();
        check("ctrl", got_ctrl, exp_ctrl);
        check("ctrl_nb", got_ctrl_nb, exp_ctrl);
        if (exp_valid) begin
            check("data1", d1, exp_d1);
            check("data2", d2, exp_d2);
            check("data1_nb", d1_nb, exp_d1_nb);
            check("data2_nb", d2_nb, exp_d2_nb);
            check("imm", imm, exp_imm);
            check("pc", pc, exp_pc);
            check("fields", {rs_o, rt_o, rd_o}, {exp_rs, exp_rt, exp_rd});
        end
    endtask

    task automatic do_cycle(input logic [31:0] ins, input logic [31:0] pcv, input logic en, fl,
                            input logic we, input logic [4:0] wa, input logic [31:0] wd,
                            input logic emr, input logic [4:0] ert, output logic st_seen);
        logic [13:0] d;
        logic        st;
        logic [4:0]  rs, rt;
        @(negedge clock);
        instruction = ins; pc_plus4 = pcv; enable = en; flush = fl;
        wb_we = we; wb_addr = wa; wb_data = wd; ex_mem_read = emr; ex_rt = ert;
        rs = ins[25:21];
        rt = ins[20:16];
        st = emr && ert != 0 && (ert == rs || ert == rt) && !fl;
        #1;
        st_seen = stall;
        check("stall", stall, st);
        check("stall_nb", stall_nb, st);
        if (en) begin
            d         = ref_decode(ins);
            exp_ctrl  = (fl || st) ? 13'h0 : d[12:0];
            exp_valid = !(fl || st);
            exp_d1    = m_read(rs, 1, we, wa, wd);
            exp_d2    = m_read(rt, 1, we, wa, wd);
            exp_d1_nb = m_read(rs, 0, we, wa, wd);
            exp_d2_nb = m_read(rt, 0, we, wa, wd);
            exp_imm   = d[13] ? {16'h0, ins[15:0]} : {{16{ins[15]}}, ins[15:0]};
            exp_pc    = pcv;
            exp_rs    = rs;
            exp_rt    = rt;
            exp_rd    = ins[15:11];
        end
        if (we && wa != 0) m_rf[wa] = wd;
        @(posedge clock);
        #1;
        check_outputs();
    endtask

    logic        st;
    logic [5:0]  ops [7] = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h0C, 6'h0D, 6'h04};
    logic [31:0] rins;
    logic [5:0]  rop;

    initial begin
        reset = 1'b1; enable = 1'b1; flush = 1'b0; instruction = '0; pc_plus4 = '0;
        wb_we = 1'b0; wb_addr = '0; wb_data = '0; ex_mem_read = 1'b0; ex_rt = '0;
        model_reset();
        #12;
        check_outputs();
        @(negedge clock);
        reset = 1'b0;

        // Write r5 then read it back through ADD r3,r5,r0.
        do_cycle(32'h0, 32'h4, 1, 0, 1, 5'd5, 32'hAA, 0, 0, st);
        do_cycle(r_ins(5, 0, 3, 6'h20), 32'h8, 1, 0, 0, 0, 0, 0, 0, st);
        check("wr_rd_d1", d1, 32'hAA);
        check("wr_rd_d2", d2, 32'h0);
        check("wr_rd_aluop", alu_op, 6'h20);
        check("wr_rd_regdst", reg_dst, 1'b1);

        // Same-cycle write-back of r7 while ADD r1,r7,r7 is decoded.
        do_cycle(r_ins(7, 7, 1, 6'h20), 32'hC, 1, 0, 1, 5'd7, 32'h1234, 0, 0, st);
        check("byp_d1", d1, 32'h1234);
        check("byp_d2", d2, 32'h1234);
        check("nobyp_d1", d1_nb, 32'h0);
        check("nobyp_d2", d2_nb, 32'h0);

        // Immediate extension.
        do_cycle(i_ins(6'h08, 0, 2, 16'hFFFF), 32'h10, 1, 0, 0, 0, 0, 0, 0, st);
        check("addi_imm", imm, 32'hFFFF_FFFF);
        do_cycle(i_ins(6'h0D, 0, 2, 16'hFFFF), 32'h14, 1, 0, 0, 0, 0, 0, 0, st);
        check("ori_imm", imm, 32'h0000_FFFF);
        check("ori_aluop", alu_op, 6'h25);

        // Load-use: ADD r2,r4,r1 behind a load into r4, then the r0 variant.
        do_cycle(r_ins(4, 1, 2, 6'h20), 32'h18, 1, 0, 0, 0, 0, 1, 5'd4, st);
        check("lu_stall", st, 1'b1);
        check("lu_bubble", got_ctrl, 13'h0);
        do_cycle(r_ins(0, 1, 2, 6'h20), 32'h1C, 1, 0, 0, 0, 0, 1, 5'd0, st);
        check("lu_r0_stall", st, 1'b0);

        // Flush overrides the stall and still bubbles.
        do_cycle(r_ins(4, 1, 2, 6'h20), 32'h20, 1, 1, 0, 0, 0, 1, 5'd4, st);
        check("flush_stall", st, 1'b0);
        check("flush_bubble", reg_write, 1'b0);

        // Freeze: load an ORI, then hold it while a different instruction is presented.
        do_cycle(i_ins(6'h0D, 5, 6, 16'h00F0), 32'h24, 1, 0, 0, 0, 0, 0, 0, st);
        do_cycle(r_ins(5, 5, 9, 6'h22), 32'h28, 0, 0, 0, 0, 0, 0, 0, st);
        check("freeze_aluop", alu_op, 6'h25);
        check("freeze_pc", pc, 32'h24);

        // r0 write ignored, both via bypass and afterwards.
        do_cycle(r_ins(0, 0, 1, 6'h20), 32'h2C, 1, 0, 1, 5'd0, 32'hDEAD, 0, 0, st);
        check("r0_byp", d1, 32'h0);
        do_cycle(r_ins(0, 0, 1, 6'h20), 32'h30, 1, 0, 0, 0, 0, 0, 0, st);
        check("r0_read", d2, 32'h0);

        // Unknown opcode decodes as a NOP.
        do_cycle(i_ins(6'h3F, 1, 2, 16'h1234), 32'h34, 1, 0, 0, 0, 0, 0, 0, st);
        check("op3f_ctrl", got_ctrl, 13'h0);

        // Reset asserted away from any edge clears ID/EX at once and wipes r5.
        do_cycle(r_ins(5, 5, 3, 6'h20), 32'h38, 1, 0, 0, 0, 0, 0, 0, st);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        check("rst_pc", pc, 32'h0);
        @(posedge clock);
        #3 reset = 1'b0;
        do_cycle(r_ins(5, 0, 3, 6'h20), 32'h3C, 1, 0, 0, 0, 0, 0, 0, st);
        check("rst_r5", d1, 32'h0);

        // Randomized traffic on a small register window so hazards and bypasses collide often.
        for (int n = 0; n < 400; n++) begin
            rop = ($urandom_range(0, 9) > 7) ? 6'($urandom()) : ops[$urandom_range(0, 6)];
            rins = {rop, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom())};
            do_cycle(rins, $urandom(), ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0),
                     ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom(),
                     ($urandom_range(0, 9) < 3), 5'($urandom_range(0, 7)), st);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
